// File: rtl/xgmii_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xgmii_pkg
//  Description : XGMII control characters, the synthetic terminate word and
//                the arbiter state encoding shared by the RX frame arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package xgmii_pkg;

    localparam logic [7:0]  XGMII_START = 8'hFB;
    localparam logic [7:0]  XGMII_TERM  = 8'hFD;
    localparam logic [7:0]  XGMII_IDLE  = 8'h07;

    // Terminate in lane 0 followed by idles on all remaining lanes.
    localparam logic [71:0] ABORT_WORD  = {8'hFF, {7{XGMII_IDLE}}, XGMII_TERM};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_ABORT = 2'd2,
        ST_DROP  = 2'd3
    } arb_state_t;

    function automatic logic is_sof(input logic [7:0] rxc, input logic [7:0] rxd_lane0);
        return rxc[0] && (rxd_lane0 == XGMII_START);
    endfunction

    // Any control lane marks a word as a potential frame end.
    function automatic logic has_ctrl(input logic [7:0] rxc);
        return rxc != 8'h00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xgmii_arb_stats.sv
`default_nettype none
// ============================================================================
//  Module      : xgmii_arb_stats
//  Description : Wrapping event counters for the XGMII RX frame arbiter.
//                Instantiated only when XGMII_ARB_STATS_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module xgmii_arb_stats #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frm0_inc,
    input  logic             frm1_inc,
    input  logic             trunc_inc,
    input  logic             junk_inc,
    output logic [CNT_W-1:0] stat_frm0,
    output logic [CNT_W-1:0] stat_frm1,
    output logic [CNT_W-1:0] stat_trunc,
    output logic [CNT_W-1:0] stat_junk
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_frm0  <= '0;
            stat_frm1  <= '0;
            stat_trunc <= '0;
            stat_junk  <= '0;
        end else begin
            if (frm0_inc)  stat_frm0  <= stat_frm0  + 1'b1;
            if (frm1_inc)  stat_frm1  <= stat_frm1  + 1'b1;
            if (trunc_inc) stat_trunc <= stat_trunc + 1'b1;
            if (junk_inc)  stat_junk  <= stat_junk  + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/xgmii_rx_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : xgmii_rx_frame_arbiter
//  Description : Frame-granular 2:1 round-robin merge of two FWFT XGMII-RX
//                FIFOs with max-length truncation and junk discard.
//                Optional counters: define XGMII_ARB_STATS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module xgmii_rx_frame_arbiter
    import xgmii_pkg::*;
#(
    parameter int MAX_WORDS = 192
`ifdef XGMII_ARB_STATS_EN
   ,parameter int CNT_W     = 32
`endif
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [71:0] rx0_dout,
    input  logic        rx0_empty,
    output logic        rx0_rd_en,
    input  logic [71:0] rx1_dout,
    input  logic        rx1_empty,
    output logic        rx1_rd_en,
    output logic [71:0] din,
    input  logic        full,
    output logic        wr_en,
    output logic        busy
`ifdef XGMII_ARB_STATS_EN
   ,output logic [CNT_W-1:0] stat_frm0,
    output logic [CNT_W-1:0] stat_frm1,
    output logic [CNT_W-1:0] stat_trunc,
    output logic [CNT_W-1:0] stat_junk
`endif
);

    localparam int                WCNT_W    = $clog2(MAX_WORDS);
    localparam logic [WCNT_W-1:0] CNT_LAST  = WCNT_W'(MAX_WORDS - 1);
    localparam logic [WCNT_W-1:0] CNT_ABORT = WCNT_W'(MAX_WORDS - 2);

    arb_state_t        state;
    logic              sel;
    logic              last;
    logic [WCNT_W-1:0] word_cnt;

    logic [71:0] head_sel;
    logic        empty_sel;
    logic        sof0;
    logic        sof1;
    logic        junk0;
    logic        junk1;
    logic        any_sof;
    logic        pick;
    logic        xfer;
    logic        eof_hit;
    logic        abort_hit;
    logic        drop_pop;
    logic        drop_end;

    assign head_sel  = sel ? rx1_dout  : rx0_dout;
    assign empty_sel = sel ? rx1_empty : rx0_empty;

    assign sof0  = !rx0_empty &&  is_sof(rx0_dout[71:64], rx0_dout[7:0]);
    assign sof1  = !rx1_empty &&  is_sof(rx1_dout[71:64], rx1_dout[7:0]);
    assign junk0 = !rx0_empty && !is_sof(rx0_dout[71:64], rx0_dout[7:0]);
    assign junk1 = !rx1_empty && !is_sof(rx1_dout[71:64], rx1_dout[7:0]);

    // On a tie the port that did not finish the previous frame wins.
    assign any_sof = sof0 || sof1;
    assign pick    = (sof0 && sof1) ? ~last : sof1;

    // The SOF word itself carries a control lane, so it never counts as EOF.
    assign xfer      = (state == ST_PASS) && !empty_sel && !full;
    assign eof_hit   = xfer && has_ctrl(head_sel[71:64]) && (word_cnt != '0);
    assign abort_hit = xfer && !eof_hit && (word_cnt == CNT_ABORT);
    assign drop_pop  = (state == ST_DROP) && !empty_sel;
    assign drop_end  = drop_pop && has_ctrl(head_sel[71:64]);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= ST_IDLE;
            sel      <= 1'b0;
            last     <= 1'b1;
            word_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_sof) begin
                        sel      <= pick;
                        word_cnt <= '0;
                        state    <= ST_PASS;
                    end
                end
                ST_PASS: begin
                    if (xfer) begin
                        if (word_cnt != CNT_LAST) begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                        if (eof_hit) begin
                            state <= ST_IDLE;
                            last  <= sel;
                        end else if (abort_hit) begin
                            state <= ST_ABORT;
                        end
                    end
                end
                ST_ABORT: begin
                    if (!full) begin
                        state <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (drop_end) begin
                        state <= ST_IDLE;
                        last  <= sel;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Pops are suppressed while reset is held so no word is lost mid-reset.
    always_comb begin
        rx0_rd_en = 1'b0;
        rx1_rd_en = 1'b0;
        wr_en     = 1'b0;
        din       = '0;
        if (!sys_rst) begin
            case (state)
                ST_IDLE: begin
                    rx0_rd_en = junk0;
                    rx1_rd_en = junk1;
                end
                ST_PASS: begin
                    if (xfer) begin
                        wr_en     = 1'b1;
                        din       = head_sel;
                        rx0_rd_en = !sel;
                        rx1_rd_en = sel;
                    end
                end
                ST_ABORT: begin
                    if (!full) begin
                        wr_en = 1'b1;
                        din   = ABORT_WORD;
                    end
                end
                ST_DROP: begin
                    if (drop_pop) begin
                        rx0_rd_en = !sel;
                        rx1_rd_en = sel;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

`ifdef XGMII_ARB_STATS_EN
    logic junk_pop;

    assign junk_pop = (state == ST_IDLE) && (junk0 || junk1);

    xgmii_arb_stats #(
        .CNT_W      (CNT_W)
    ) u_stats (
        .clk        (sys_clk),
        .rst        (sys_rst),
        .frm0_inc   (eof_hit && !sel),
        .frm1_inc   (eof_hit &&  sel),
        .trunc_inc  (abort_hit),
        .junk_inc   (junk_pop),
        .stat_frm0  (stat_frm0),
        .stat_frm1  (stat_frm1),
        .stat_trunc (stat_trunc),
        .stat_junk  (stat_junk)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_xgmii_rx_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xgmii_rx_frame_arbiter
//  Description : Directed self-checking bench for xgmii_rx_frame_arbiter with
//                FWFT FIFO models on both inputs and a write capture queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_xgmii_rx_frame_arbiter;

    localparam logic [71:0] ABORT_EXP = {8'hFF, 64'h07070707070707FD};
    localparam logic [71:0] IDLE_W    = {8'hFF, 64'h0707070707070707};

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [71:0] rx0_dout;
    logic        rx0_empty;
    logic        rx0_rd_en;
    logic [71:0] rx1_dout;
    logic        rx1_empty;
    logic        rx1_rd_en;
    logic [71:0] din;
    logic        full;
    logic        wr_en;
    logic        busy;
`ifdef XGMII_ARB_STATS_EN
    logic [31:0] stat_frm0;
    logic [31:0] stat_frm1;
    logic [31:0] stat_trunc;
    logic [31:0] stat_junk;
`endif

    xgmii_rx_frame_arbiter dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .rx0_dout   (rx0_dout),
        .rx0_empty  (rx0_empty),
        .rx0_rd_en  (rx0_rd_en),
        .rx1_dout   (rx1_dout),
        .rx1_empty  (rx1_empty),
        .rx1_rd_en  (rx1_rd_en),
        .din        (din),
        .full       (full),
        .wr_en      (wr_en),
        .busy       (busy)
`ifdef XGMII_ARB_STATS_EN
       ,.stat_frm0  (stat_frm0),
        .stat_frm1  (stat_frm1),
        .stat_trunc (stat_trunc),
        .stat_junk  (stat_junk)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    logic [71:0] q0[$];
    logic [71:0] q1[$];
    logic [71:0] out_q[$];
    logic [71:0] exp_q[$];
    logic [71:0] frame[$];
    int          wr_cyc[$];
    int          cyc = 0;
    int          pops0 = 0;
    int          pops1 = 0;
    int          rdwr_err = 0;
    int          full_err = 0;
    int          din_err = 0;
    bit          monitor_rdwr = 1'b0;
    bit          toggle_full = 1'b0;
    bit          s_rd0 = 1'b0;
    bit          s_rd1 = 1'b0;
    int          vec = 0;
    int          miss = 0;

    task automatic refresh();
        rx0_empty = (q0.size() == 0);
        rx0_dout  = rx0_empty ? 72'h0 : q0[0];
        rx1_empty = (q1.size() == 0);
        rx1_dout  = rx1_empty ? 72'h0 : q1[0];
    endtask

    // Outputs are settled mid-cycle: capture writes and pops on the falling edge.
    always @(negedge sys_clk) begin
        cyc++;
        s_rd0 = rx0_rd_en;
        s_rd1 = rx1_rd_en;
        if (wr_en) begin
            out_q.push_back(din);
            wr_cyc.push_back(cyc);
        end
        if (rx0_rd_en) pops0++;
        if (rx1_rd_en) pops1++;
        if (monitor_rdwr && ((rx0_rd_en || rx1_rd_en) != wr_en)) rdwr_err++;
        if (wr_en && full) full_err++;
        if (!wr_en && din !== 72'h0) din_err++;
    end

    always @(posedge sys_clk) begin
        #1;
        if (s_rd0 && q0.size() > 0) void'(q0.pop_front());
        if (s_rd1 && q1.size() > 0) void'(q1.pop_front());
        s_rd0 = 1'b0;
        s_rd1 = 1'b0;
        if (toggle_full) full = ~full;
        refresh();
    end

    task automatic tick();
        @(posedge sys_clk);
        #3;
    endtask

    task automatic push_frame(input int port, input logic [7:0] tag, input int n);
        frame.delete();
        frame.push_back({8'h01, 56'hD5555555555555, 8'hFB});
        for (int i = 1; i < n - 1; i++)
            frame.push_back({8'h00, tag, 8'hA5, 16'h0000, 16'(i), 16'h1234});
        frame.push_back({8'hF0, 32'h070707FD, 8'h00, tag, 16'hBEEF});
        foreach (frame[i]) begin
            if (port == 0) q0.push_back(frame[i]);
            else           q1.push_back(frame[i]);
        end
        refresh();
    endtask

    task automatic drain(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (out_q.size() >= target && q0.size() == 0 && q1.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) tick();
    endtask

    task automatic clear_capture();
        out_q.delete();
        wr_cyc.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (2) tick();
        vec++;
        if ({wr_en, rx0_rd_en, rx1_rd_en, busy} !== 4'b0000) begin
            miss++;
            $display("FAIL reset_ctrl: got %b expected 0000", {wr_en, rx0_rd_en, rx1_rd_en, busy});
        end
        vec++;
        if (din !== 72'h0) begin
            miss++;
            $display("FAIL reset_din: got %h expected 0", din);
        end
`ifdef XGMII_ARB_STATS_EN
        vec++;
        if ({stat_frm0, stat_frm1, stat_trunc, stat_junk} !== 128'h0) begin
            miss++;
            $display("FAIL reset_stats: got %h expected 0", {stat_frm0, stat_frm1, stat_trunc, stat_junk});
        end
`endif
        sys_rst = 1'b0;
        repeat (3) tick();
        vec++;
        if (busy !== 1'b0 || out_q.size() != 0) begin
            miss++;
            $display("FAIL idle_after_reset: got busy=%b writes=%0d expected busy=0 writes=0", busy, out_q.size());
        end
    endtask

    task automatic test_single_frame();
        bit ok;
        int c0;
        clear_capture();
        c0 = cyc;
        push_frame(0, 8'h10, 8);
        foreach (frame[i]) exp_q.push_back(frame[i]);
        drain(8, 40, ok);
        vec++;
        if (!ok || out_q.size() != 8) begin
            miss++;
            $display("FAIL single_count: got %0d writes (done=%0b) expected 8", out_q.size(), ok);
        end
        for (int i = 0; i < 8; i++) begin
            vec++;
            if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
                miss++;
                $display("FAIL single_word[%0d]: got %h expected %h", i, (i < out_q.size()) ? out_q[i] : 72'h0, exp_q[i]);
            end
        end
        vec++;
        if (wr_cyc.size() != 8 || wr_cyc[0] != c0 + 2 || wr_cyc[7] != c0 + 9) begin
            miss++;
            $display("FAIL single_timing: got first=%0d last=%0d expected %0d %0d",
                     (wr_cyc.size() > 0) ? wr_cyc[0] - c0 : -1, (wr_cyc.size() > 7) ? wr_cyc[7] - c0 : -1, 2, 9);
        end
`ifdef XGMII_ARB_STATS_EN
        vec++;
        if (stat_frm0 !== 32'd1) begin
            miss++;
            $display("FAIL single_stat_frm0: got %0d expected 1", stat_frm0);
        end
`endif
    endtask

    task automatic test_tie();
        bit ok;
        int c0;
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        tick();
        clear_capture();
        c0 = cyc;
        push_frame(0, 8'h20, 3);
        foreach (frame[i]) exp_q.push_back(frame[i]);
        push_frame(1, 8'h21, 4);
        foreach (frame[i]) exp_q.push_back(frame[i]);
        drain(7, 60, ok);
        vec++;
        if (!ok || out_q.size() != 7) begin
            miss++;
            $display("FAIL tie_count: got %0d writes (done=%0b) expected 7", out_q.size(), ok);
        end
        for (int i = 0; i < 7; i++) begin
            vec++;
            if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
                miss++;
                $display("FAIL tie_word[%0d]: got %h expected %h", i, (i < out_q.size()) ? out_q[i] : 72'h0, exp_q[i]);
            end
        end
        vec++;
        if (wr_cyc.size() != 7 || wr_cyc[2] != c0 + 4 || wr_cyc[3] != c0 + 6) begin
            miss++;
            $display("FAIL tie_bubble: got p0_end=%0d p1_start=%0d expected 4 6",
                     (wr_cyc.size() > 2) ? wr_cyc[2] - c0 : -1, (wr_cyc.size() > 3) ? wr_cyc[3] - c0 : -1);
        end
    endtask

    task automatic test_full_toggle();
        bit ok;
        clear_capture();
        rdwr_err = 0;
        full_err = 0;
        din_err = 0;
        monitor_rdwr = 1'b1;
        toggle_full = 1'b1;
        push_frame(1, 8'h30, 6);
        foreach (frame[i]) exp_q.push_back(frame[i]);
        drain(6, 60, ok);
        toggle_full = 1'b0;
        monitor_rdwr = 1'b0;
        full = 1'b0;
        tick();
        vec++;
        if (!ok || out_q.size() != 6) begin
            miss++;
            $display("FAIL full_count: got %0d writes (done=%0b) expected 6", out_q.size(), ok);
        end
        for (int i = 0; i < 6; i++) begin
            vec++;
            if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
                miss++;
                $display("FAIL full_word[%0d]: got %h expected %h", i, (i < out_q.size()) ? out_q[i] : 72'h0, exp_q[i]);
            end
        end
        vec++;
        if (rdwr_err != 0 || full_err != 0) begin
            miss++;
            $display("FAIL full_rd_eq_wr: got rd!=wr cycles=%0d writes_while_full=%0d expected 0 0", rdwr_err, full_err);
        end
        vec++;
        if (din_err != 0) begin
            miss++;
            $display("FAIL din_zero_when_idle: got %0d nonzero cycles expected 0", din_err);
        end
    endtask

    task automatic test_truncate();
        bit ok;
        int p0;
        clear_capture();
        p0 = pops0;
        push_frame(0, 8'h40, 200);
        for (int i = 0; i < 191; i++) exp_q.push_back(frame[i]);
        exp_q.push_back(ABORT_EXP);
        push_frame(1, 8'h41, 3);
        foreach (frame[i]) exp_q.push_back(frame[i]);
        drain(195, 500, ok);
        vec++;
        if (!ok || out_q.size() != 195) begin
            miss++;
            $display("FAIL trunc_count: got %0d writes (done=%0b) expected 195", out_q.size(), ok);
        end
        for (int i = 189; i < 195; i++) begin
            vec++;
            if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
                miss++;
                $display("FAIL trunc_word[%0d]: got %h expected %h", i, (i < out_q.size()) ? out_q[i] : 72'h0, exp_q[i]);
            end
        end
        vec++;
        if (out_q.size() > 0 && out_q[0] !== exp_q[0]) begin
            miss++;
            $display("FAIL trunc_first: got %h expected %h", out_q[0], exp_q[0]);
        end
        vec++;
        if (pops0 - p0 != 200) begin
            miss++;
            $display("FAIL trunc_pops: got %0d expected 200", pops0 - p0);
        end
`ifdef XGMII_ARB_STATS_EN
        vec++;
        if (stat_trunc !== 32'd1) begin
            miss++;
            $display("FAIL trunc_stat: got %0d expected 1", stat_trunc);
        end
`endif
    endtask

    task automatic test_junk();
        bit ok;
        int p1;
        clear_capture();
        p1 = pops1;
        for (int i = 0; i < 5; i++) q1.push_back(IDLE_W);
        refresh();
        drain(0, 30, ok);
        vec++;
        if (!ok || pops1 - p1 != 5) begin
            miss++;
            $display("FAIL junk_pops: got %0d (done=%0b) expected 5", pops1 - p1, ok);
        end
        vec++;
        if (out_q.size() != 0) begin
            miss++;
            $display("FAIL junk_writes: got %0d expected 0", out_q.size());
        end
`ifdef XGMII_ARB_STATS_EN
        vec++;
        if (stat_junk !== 32'd5) begin
            miss++;
            $display("FAIL junk_stat: got %0d expected 5", stat_junk);
        end
`endif
    endtask

    task automatic test_mid_reset();
        bit ok;
        clear_capture();
        push_frame(0, 8'h60, 10);
        repeat (5) tick();
        vec++;
        if (busy !== 1'b1 || out_q.size() == 0) begin
            miss++;
            $display("FAIL midrst_pre: got busy=%b writes=%0d expected busy=1 writes>0", busy, out_q.size());
        end
        sys_rst = 1'b1;
        #1;
        vec++;
        if ({wr_en, rx0_rd_en, rx1_rd_en, busy} !== 4'b0000) begin
            miss++;
            $display("FAIL midrst_ctrl: got %b expected 0000", {wr_en, rx0_rd_en, rx1_rd_en, busy});
        end
        tick();
        sys_rst = 1'b0;
        clear_capture();
        push_frame(0, 8'h61, 3);
        foreach (frame[i]) exp_q.push_back(frame[i]);
        drain(3, 60, ok);
        vec++;
        if (!ok || out_q.size() != 3) begin
            miss++;
            $display("FAIL midrst_count: got %0d writes (done=%0b) expected 3", out_q.size(), ok);
        end
        for (int i = 0; i < 3; i++) begin
            vec++;
            if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
                miss++;
                $display("FAIL midrst_word[%0d]: got %h expected %h", i, (i < out_q.size()) ? out_q[i] : 72'h0, exp_q[i]);
            end
        end
    endtask

    initial begin
        full = 1'b0;
        refresh();
        test_reset();
        test_single_frame();
        test_tie();
        test_full_toggle();
        test_truncate();
        test_junk();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
